// File: rtl/ym2413_slot_sequencer_if.sv
// CPU register-write handshake between the host bus and the YM2413 slot sequencer.
interface ym2413_slot_sequencer_if;
  logic       wr_req;
  logic [5:0] wr_addr;
  logic       wr_grant;
  logic       wr_busy;

  modport master (output wr_req, output wr_addr, input wr_grant, input wr_busy);
  modport slave  (input wr_req, input wr_addr, output wr_grant, output wr_busy);
endinterface

// File: rtl/ym2413_slot_sequencer.sv
// YM2413 master timing: walks the 18 operator slots per sample frame, issues slot/sample
// strobes and holds off CPU register writes that would disturb the parameter generator.
module ym2413_slot_sequencer #(
  parameter int CYC_PER_SLOT = 4,
  parameter int FRAME_LEN    = 80
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  input  logic                         rhy_en_i,
  ym2413_slot_sequencer_if.slave       wr,
  output logic [3:0]                   ch_select_o,
  output logic                         op_sel_o,
  output logic [4:0]                   slot_o,
  output logic [2:0]                   slot_phase_o,
  output logic                         slot_start_o,
  output logic                         param_valid_o,
  output logic                         rhy_slot_o,
  output logic                         sample_strobe_o
);

  localparam int FCNT_W = $clog2(FRAME_LEN);
  localparam logic [FCNT_W-1:0] FCNT_GAP     = FCNT_W'(18 * CYC_PER_SLOT);
  localparam logic [FCNT_W-1:0] FCNT_LAST    = FCNT_W'(FRAME_LEN - 1);
  localparam logic [FCNT_W-1:0] FCNT_GLB_MAX = FCNT_W'(FRAME_LEN - 3);
  localparam logic [2:0]        PH_LAST      = 3'(CYC_PER_SLOT - 1);
  localparam logic [4:0]        SLOT_GAP     = 5'd31;

  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [4:0]        slot_q, slot_d;
  logic [2:0]        phase_q, phase_d;
  logic [3:0]        ch_q, ch_d;
  logic              in_slot_d;
  logic              op_q, pv_q, start_q, smp_q, rhy_slot_q;
  logic              rhy_mode_q, rhy_mode_d;
  logic              gnt_last_q;
  logic              req_blk_q;

  logic [3:0]        wr_ch;
  logic              is_ch, is_glb, in_gap, wr_ok, grant;

  // Next position in the frame, derived incrementally so no divider is needed.
  always_comb begin
    fcnt_d     = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + FCNT_W'(1);
    slot_d     = SLOT_GAP;
    phase_d    = '0;
    if (fcnt_d == '0) begin
      slot_d = 5'd0;
    end else if (fcnt_d < FCNT_GAP) begin
      if (phase_q == PH_LAST) begin
        slot_d = slot_q + 5'd1;
      end else begin
        slot_d  = slot_q;
        phase_d = phase_q + 3'd1;
      end
    end
    in_slot_d  = (slot_d != SLOT_GAP);
    ch_d       = in_slot_d ? {1'b0, slot_d[4:1]} : 4'hF;
    rhy_mode_d = (fcnt_d == '0) ? rhy_en_i : rhy_mode_q;
  end

  // Write arbitration: a channel write must avoid both the channel on the bus now and
  // the one presented next clock; instrument/rhythm writes wait for the frame gap.
  always_comb begin
    wr_ch  = wr.wr_addr[3:0];
    is_ch  = (wr.wr_addr[5:4] != 2'd0) && (wr_ch <= 4'd8);
    is_glb = (wr.wr_addr <= 6'h07) || (wr.wr_addr == 6'h0E);
    in_gap = (fcnt_q >= FCNT_GAP);
    if (is_ch) begin
      wr_ok = (wr_ch != ch_q) && (wr_ch != ch_d);
    end else if (is_glb) begin
      wr_ok = in_gap && (fcnt_q <= FCNT_GLB_MAX);
    end else begin
      wr_ok = 1'b1;
    end
    grant = en_i && !rst && wr.wr_req && !gnt_last_q && !req_blk_q && wr_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q     <= FCNT_GAP;
      slot_q     <= SLOT_GAP;
      phase_q    <= '0;
      ch_q       <= 4'hF;
      op_q       <= 1'b0;
      pv_q       <= 1'b0;
      start_q    <= 1'b0;
      smp_q      <= 1'b0;
      rhy_slot_q <= 1'b0;
      rhy_mode_q <= 1'b0;
      gnt_last_q <= 1'b0;
      // A request straddling reset is discarded until the requester re-presents it.
      req_blk_q  <= wr.wr_req;
    end else begin
      gnt_last_q <= grant;
      if (!wr.wr_req) req_blk_q <= 1'b0;
      if (en_i) begin
        fcnt_q     <= fcnt_d;
        slot_q     <= slot_d;
        phase_q    <= phase_d;
        ch_q       <= ch_d;
        op_q       <= in_slot_d && slot_d[0];
        pv_q       <= in_slot_d && (phase_d != 3'd0);
        start_q    <= in_slot_d && (phase_d == 3'd0);
        smp_q      <= (fcnt_d == FCNT_LAST);
        rhy_mode_q <= rhy_mode_d;
        rhy_slot_q <= rhy_mode_d && in_slot_d && (ch_d >= 4'd6);
      end
    end
  end

  assign ch_select_o     = ch_q;
  assign op_sel_o        = op_q;
  assign slot_o          = slot_q;
  assign slot_phase_o    = phase_q;
  assign param_valid_o   = pv_q;
  assign rhy_slot_o      = rhy_slot_q;
  assign slot_start_o    = start_q && en_i;
  assign sample_strobe_o = smp_q && en_i;
  assign wr.wr_grant     = grant;
  assign wr.wr_busy      = wr.wr_req && !grant && !rst;

endmodule

// File: tb/tb_ym2413_slot_sequencer.sv
// Self-checking bench for ym2413_slot_sequencer with default CYC_PER_SLOT=4, FRAME_LEN=80.
module tb_ym2413_slot_sequencer;
  logic clk = 1'b0;
  logic rst, en, rhy_en;
  logic [3:0] ch_select;
  logic       op_sel;
  logic [4:0] slot;
  logic [2:0] slot_phase;
  logic       slot_start, param_valid, rhy_slot, sample_strobe;
  logic [16:0] dut_vec;

  int checks = 0;
  int errors = 0;
  int m_fcnt = 72;
  bit m_rhy  = 1'b0;
  logic [16:0] exp_q[$];
  int          gq[$];

  ym2413_slot_sequencer_if wif();

  ym2413_slot_sequencer dut (
    .clk(clk), .rst(rst), .en_i(en), .rhy_en_i(rhy_en), .wr(wif.slave),
    .ch_select_o(ch_select), .op_sel_o(op_sel), .slot_o(slot), .slot_phase_o(slot_phase),
    .slot_start_o(slot_start), .param_valid_o(param_valid), .rhy_slot_o(rhy_slot),
    .sample_strobe_o(sample_strobe)
  );

  assign dut_vec = {ch_select, op_sel, slot, slot_phase, slot_start, param_valid, rhy_slot, sample_strobe};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] exp_vec(input int f, input bit e, input bit rm);
    logic [3:0] ch; logic op; logic [4:0] sl; logic [2:0] ph; logic st, pv, rh, sm;
    if (f < 72) begin
      sl = 5'(f / 4); ph = 3'(f % 4); ch = 4'(f / 8); op = sl[0];
      st = e && (ph == 3'd0); pv = (ph != 3'd0); rh = rm && (ch >= 4'd6); sm = 1'b0;
    end else begin
      ch = 4'hF; op = 1'b0; sl = 5'd31; ph = 3'd0;
      st = 1'b0; pv = 1'b0; rh = 1'b0; sm = e && (f == 79);
    end
    return {ch, op, sl, ph, st, pv, rh, sm};
  endfunction

  // One clock: reference frame counter follows the inputs sampled at the edge.
  task automatic cyc();
    int nf;
    @(posedge clk);
    if (rst) begin
      m_fcnt = 72; m_rhy = 1'b0;
    end else if (en) begin
      nf = (m_fcnt + 1) % 80;
      if (nf == 0) m_rhy = rhy_en;
      m_fcnt = nf;
    end
    #1;
  endtask

  task automatic goto(input int f);
    int n;
    n = 0;
    do begin cyc(); n++; end while (m_fcnt != f && n < 200);
  endtask

  task automatic await_grant(output int gf, output bit busy_ok, output bit got);
    got = 1'b0; busy_ok = 1'b1; gf = -1;
    for (int n = 0; n < 200 && !got; n++) begin
      if (n > 0) cyc();
      #1;
      if (wif.wr_grant === 1'b1) begin
        got = 1'b1; gf = m_fcnt;
        if (wif.wr_busy !== 1'b0) busy_ok = 1'b0;
      end else if (wif.wr_busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; rhy_en = 1'b0; wif.wr_req = 1'b1; wif.wr_addr = 6'h19;
    repeat (3) cyc();
    #1;
    checks++;
    if (dut_vec !== exp_vec(72, 1'b1, 1'b0))
      $display("FAIL reset_state actual %h required %h", dut_vec, exp_vec(72, 1'b1, 1'b0));
    if (dut_vec !== exp_vec(72, 1'b1, 1'b0)) errors++;
    checks++;
    if ({wif.wr_grant, wif.wr_busy} !== 2'b00) begin
      errors++; $display("FAIL reset_handshake actual %b required 00", {wif.wr_grant, wif.wr_busy});
    end
    rst = 1'b0; wif.wr_req = 1'b0;
  endtask

  task automatic test_frame();
    int first_start, last_smp, pv_cnt;
    logic [16:0] e;
    first_start = -1; last_smp = -1; pv_cnt = 0;
    for (int i = 0; i < 170; i++) begin
      if (i > 0) cyc();
      #1;
      exp_q.push_back(exp_vec(m_fcnt, en, m_rhy));
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++; $display("FAIL frame_outputs clk %0d actual %h required %h", i, dut_vec, e);
      end
      if (slot_start === 1'b1 && first_start < 0) first_start = i;
      if (i >= 8 && i < 88 && param_valid === 1'b1) pv_cnt++;
      if (sample_strobe === 1'b1) begin
        if (last_smp >= 0) begin
          checks++;
          if (i - last_smp != 80) begin
            errors++; $display("FAIL sample_period actual %0d required 80", i - last_smp);
          end
        end
        last_smp = i;
      end
    end
    checks++;
    if (first_start != 8) begin
      errors++; $display("FAIL first_slot_start actual %0d required 8", first_start);
    end
    checks++;
    if (pv_cnt != 54) begin
      errors++; $display("FAIL param_valid_count actual %0d required 54", pv_cnt);
    end
  endtask

  task automatic test_chan_write();
    int gf, e; bit bok, got;
    goto(23);
    wif.wr_addr = 6'h23; wif.wr_req = 1'b1; gq.push_back(32);
    await_grant(gf, bok, got);
    e = gq.pop_front();
    cyc(); wif.wr_req = 1'b0;
    checks++;
    if (!got || gf != e) begin
      errors++; $display("FAIL chan_grant_fcnt actual %0d required %0d", gf, e);
    end
    checks++;
    if (!bok) begin errors++; $display("FAIL chan_busy actual wrong required busy-until-grant"); end
  endtask

  task automatic test_global_write();
    int gf, e; bit bok, got;
    goto(8);
    wif.wr_addr = 6'h03; wif.wr_req = 1'b1; gq.push_back(72);
    await_grant(gf, bok, got);
    e = gq.pop_front();
    cyc(); wif.wr_req = 1'b0;
    checks++;
    if (!got || gf != e) begin
      errors++; $display("FAIL inst_grant_fcnt actual %0d required %0d", gf, e);
    end
    checks++;
    if (!bok) begin errors++; $display("FAIL inst_busy actual wrong required busy-until-grant"); end
    goto(78);
    wif.wr_addr = 6'h0E; wif.wr_req = 1'b1; gq.push_back(72);
    await_grant(gf, bok, got);
    e = gq.pop_front();
    cyc(); wif.wr_req = 1'b0;
    checks++;
    if (!got || gf != e) begin
      errors++; $display("FAIL rhy_reg_grant_fcnt actual %0d required %0d", gf, e);
    end
  endtask

  task automatic test_wrap_lookahead();
    int gf, e; bit bok, got;
    goto(79);
    wif.wr_addr = 6'h10; wif.wr_req = 1'b1; gq.push_back(8);
    await_grant(gf, bok, got);
    e = gq.pop_front();
    cyc(); wif.wr_req = 1'b0;
    checks++;
    if (!got || gf != e) begin
      errors++; $display("FAIL wrap_grant_fcnt actual %0d required %0d", gf, e);
    end
    checks++;
    if (!bok) begin errors++; $display("FAIL wrap_busy actual wrong required busy-until-grant"); end
  endtask

  task automatic test_back_to_back();
    int e; bit prev_g;
    goto(74);
    wif.wr_addr = 6'h19; wif.wr_req = 1'b1; prev_g = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        cyc();
        if (prev_g) wif.wr_addr = (wif.wr_addr == 6'h19) ? 6'h1A : 6'h19;
      end
      gq.push_back((i % 2 == 0) ? 1 : 0);
      #1;
      e = gq.pop_front();
      checks++;
      if (wif.wr_grant !== 1'(e) || wif.wr_busy !== 1'(1 - e)) begin
        errors++;
        $display("FAIL b2b_grant step %0d actual g%b b%b required g%0d", i, wif.wr_grant, wif.wr_busy, e);
      end
      prev_g = (wif.wr_grant === 1'b1);
    end
    cyc(); wif.wr_req = 1'b0;
  endtask

  task automatic test_en_toggle();
    int last_smp; bit prev_g;
    logic [16:0] e;
    last_smp = -1; prev_g = 1'b0;
    cyc();
    wif.wr_addr = 6'h19; wif.wr_req = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i > 0) begin
        cyc();
        if (prev_g) wif.wr_addr = (wif.wr_addr == 6'h19) ? 6'h1A : 6'h19;
      end
      en = (i % 2 == 0);
      #1;
      exp_q.push_back(exp_vec(m_fcnt, en, m_rhy));
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e || wif.wr_grant !== en) begin
        errors++;
        $display("FAIL en_toggle step %0d actual %h g%b required %h g%b", i, dut_vec, wif.wr_grant, e, en);
      end
      prev_g = (wif.wr_grant === 1'b1);
      if (sample_strobe === 1'b1) begin
        if (last_smp >= 0) begin
          checks++;
          if (i - last_smp != 160) begin
            errors++; $display("FAIL en_sample_period actual %0d required 160", i - last_smp);
          end
        end
        last_smp = i;
      end
    end
    en = 1'b1; wif.wr_req = 1'b0;
  endtask

  task automatic test_rhythm_reset();
    int rcnt, gf; bit bok, got, leak;
    logic [16:0] e;
    rhy_en = 1'b1;
    goto(0);
    rcnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (i > 0) cyc();
      #1;
      exp_q.push_back(exp_vec(m_fcnt, en, m_rhy));
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++; $display("FAIL rhythm_outputs fcnt %0d actual %h required %h", m_fcnt, dut_vec, e);
      end
      if (rhy_slot === 1'b1) rcnt++;
    end
    checks++;
    if (rcnt != 24) begin errors++; $display("FAIL rhy_slot_count actual %0d required 24", rcnt); end
    goto(40);
    wif.wr_addr = 6'h25; wif.wr_req = 1'b1; rst = 1'b1;
    #1;
    checks++;
    if ({wif.wr_grant, wif.wr_busy} !== 2'b00) begin
      errors++; $display("FAIL rst_cycle_handshake actual %b required 00", {wif.wr_grant, wif.wr_busy});
    end
    cyc(); rst = 1'b0;
    #1;
    checks++;
    if (dut_vec !== exp_vec(72, 1'b1, 1'b0)) begin
      errors++; $display("FAIL midframe_reset actual %h required %h", dut_vec, exp_vec(72, 1'b1, 1'b0));
    end
    leak = (wif.wr_grant !== 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      if (wif.wr_grant !== 1'b0) leak = 1'b1;
    end
    checks++;
    if (leak) begin errors++; $display("FAIL stale_req_grant actual 1 required 0"); end
    cyc(); wif.wr_req = 1'b0;
    cyc(); wif.wr_req = 1'b1; gq.push_back(78);
    await_grant(gf, bok, got);
    checks++;
    if (!got || gf != gq.pop_front()) begin
      errors++; $display("FAIL represent_grant_fcnt actual %0d required 78", gf);
    end
    cyc(); wif.wr_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_chan_write();
    test_global_write();
    test_wrap_lookahead();
    test_back_to_back();
    test_en_toggle();
    test_rhythm_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
